// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Scan driver for an N-digit common-cathode 7-segment display. It captures
//   a packed BCD value on load and cycles through the digits one at a time.
//   Each digit slot lasts DIV clocks: one dead-time BLANK cycle followed by
//   DIV-1 SHOW cycles. Code 4'hF is the blank code for the downstream decoder.
//   Every output is decoded from registers only, so there is no combinational
//   path from any input to any output.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   value    - packed BCD input, digit i = value[4*i+3:4*i]
//   load     - capture value into the shadow register at this edge
//   lzb      - leading-zero blanking enable (registered)
//   blank    - force the display dark (registered); the scan keeps running
//   bcd_out  - BCD code of the selected digit, 4'hF when dark or blanked
//   digit_en - one-hot active-high digit enable
//   frame    - one-cycle pulse at the start of each complete scan frame
module bcd_display_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lzb,
  input  logic                    blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    frame_q, frame_d;
  logic                    lzb_q;
  logic                    blank_q;

  logic [3:0]              sel_digit;
  logic                    sel_lz;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic                    run_zero;

  // frame_q doubles as the wrap flag: it is set only on the edge that wraps
  // idx from NUM_DIGITS-1 back to 0, so the first post-reset BLANK has no pulse.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    state_d  = SHOW;
    frame_d  = 1'b0;
    shadow_d = load ? value : shadow_q;
    if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d   = '0;
      state_d = BLANK;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d   = '0;
        frame_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      lzb_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      lzb_q    <= lzb;
      blank_q  <= blank;
    end
  end

  // lz_mask[i] is set when digits i..NUM_DIGITS-1 of the shadow are all zero,
  // built by walking down from the most significant digit.
  always_comb begin
    lz_mask  = '0;
    run_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      run_zero = run_zero & (shadow_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      lz_mask[NUM_DIGITS-1-k] = run_zero;
    end
  end

  always_comb begin
    sel_digit  = '0;
    sel_lz     = 1'b0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_digit     = shadow_q[4*i +: 4];
        sel_lz        = (i != 0) && lz_mask[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    digit_en = '0;
    bcd_out  = 4'hF;
    if (state_q == SHOW && !blank_q) begin
      digit_en = sel_onehot;
      bcd_out  = (lzb_q && sel_lz) ? 4'hF : sel_digit;
    end
  end

  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;
  localparam int unsigned W = 1 + N + 4;

  logic           clk;
  logic           rst_n;
  logic [4*N-1:0] value;
  logic           load;
  logic           lzb;
  logic           blank;
  logic [3:0]     bcd_out;
  logic [N-1:0]   digit_en;
  logic           frame;

  int n_cmp;
  int n_fail;

  // Reference model: scan position derived from elapsed cycles since reset.
  int unsigned    t;
  logic [4*N-1:0] m_shadow;
  logic           m_blank;
  logic           m_lzb;

  logic [W-1:0]   got;
  logic [W-1:0]   exp_v;

  bcd_display_scanner #(.NUM_DIGITS(N), .DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .lzb      (lzb),
    .blank    (blank),
    .bcd_out  (bcd_out),
    .digit_en (digit_en),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_out();
    int unsigned  ph  = t % D;
    int unsigned  idx = (t / D) % N;
    logic [N-1:0] en  = '0;
    logic [3:0]   b   = 4'hF;
    logic         fr  = (t > 0) && (t % (N * D) == 0);
    if (ph != 0 && !m_blank) begin
      en[idx] = 1'b1;
      b = 4'(m_shadow >> (4 * idx));
      if (m_lzb && idx > 0 && (m_shadow >> (4 * idx)) == '0) b = 4'hF;
    end
    return {fr, en, b};
  endfunction

  task automatic model_reset();
    t = 0; m_shadow = '0; m_blank = 1'b0; m_lzb = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    t++;
    if (load) m_shadow = value;
    m_blank = blank;
    m_lzb   = lzb;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; value = '0; load = 1'b0; lzb = 1'b0; blank = 1'b0;
    #2;
    got = {frame, digit_en, bcd_out};
    n_cmp++;
    if (got !== {1'b0, {N{1'b0}}, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_t0 got=%h exp=%h", got, {1'b0, {N{1'b0}}, 4'hF});
    end
    repeat (3) @(negedge clk);
    got = {frame, digit_en, bcd_out};
    n_cmp++;
    if (got !== {1'b0, {N{1'b0}}, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", got, {1'b0, {N{1'b0}}, 4'hF});
    end
  endtask

  task automatic test_basic_scan();
    value = 16'h1234; load = 1'b1;
    rst_n = 1'b1;
    model_reset();
    #1;
    got = {frame, digit_en, bcd_out}; exp_v = model_out();
    n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL scan_t0 got=%h exp=%h", got, exp_v);
    end
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * N * D + 2; i++) begin
      got = {frame, digit_en, bcd_out}; exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL scan t=%0d got=%h exp=%h", t, got, exp_v);
      end
      if (t == N * D) begin
        n_cmp++;
        if (frame !== 1'b1) begin
          n_fail++; $display("FAIL frame_first got=%b exp=1", frame);
        end
      end
      tick();
    end
  endtask

  task automatic test_lzb();
    logic [4*N-1:0] vals [3] = '{16'h0050, 16'h0000, 16'h0000};
    logic           lzbs [3] = '{1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 3; s++) begin
      value = vals[s]; lzb = lzbs[s]; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < N * D; i++) begin
        got = {frame, digit_en, bcd_out}; exp_v = model_out();
        n_cmp++;
        if (got !== exp_v) begin
          n_fail++; $display("FAIL lzb s=%0d t=%0d got=%h exp=%h", s, t, got, exp_v);
        end
        tick();
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_load_midslot();
    int  k = 0;
    while (k < 64 && !((t / D) % N == 2 && t % D == 1)) begin
      tick(); k++;
    end
    n_cmp++;
    if (k >= 64) begin
      n_fail++; $display("FAIL midslot_reach got=timeout exp=idx2");
    end
    value = 16'h9876; load = 1'b1;
    tick();
    load = 1'b0;
    got = {frame, digit_en, bcd_out};
    n_cmp++;
    if (got !== {1'b0, 4'b0100, 4'h8}) begin
      n_fail++; $display("FAIL midslot_load got=%h exp=%h", got, {1'b0, 4'b0100, 4'h8});
    end
    for (int i = 0; i < N * D; i++) begin
      tick();
      got = {frame, digit_en, bcd_out}; exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL midslot t=%0d got=%h exp=%h", t, got, exp_v);
      end
    end
  endtask

  task automatic test_blank();
    blank = 1'b1;
    for (int i = 0; i < 6 + N * D; i++) begin
      if (i == 6) blank = 1'b0;
      tick();
      got = {frame, digit_en, bcd_out}; exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL blank t=%0d got=%h exp=%h", t, got, exp_v);
      end
      if (i < 6) begin
        n_cmp++;
        if (digit_en !== '0 || bcd_out !== 4'hF) begin
          n_fail++; $display("FAIL blank_dark got=%h/%h exp=0/f", digit_en, bcd_out);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    while (k < 64 && !((t / D) % N == 3 && t % D == 2)) begin
      tick(); k++;
    end
    n_cmp++;
    if (k >= 64) begin
      n_fail++; $display("FAIL areset_reach got=timeout exp=idx3");
    end
    #2 rst_n = 1'b0;
    value = 16'hFFFF; load = 1'b1;
    #1;
    got = {frame, digit_en, bcd_out};
    n_cmp++;
    if (got !== {1'b0, {N{1'b0}}, 4'hF}) begin
      n_fail++; $display("FAIL areset_now got=%h exp=%h", got, {1'b0, {N{1'b0}}, 4'hF});
    end
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < N * D + 2; i++) begin
      got = {frame, digit_en, bcd_out}; exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL areset_restart t=%0d got=%h exp=%h", t, got, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_nonbcd();
    value = 16'hA0B1; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3 * N * D; i++) begin
      got = {frame, digit_en, bcd_out}; exp_v = model_out();
      n_cmp++;
      if (got !== exp_v || $countones(digit_en) > 1) begin
        n_fail++; $display("FAIL nonbcd t=%0d got=%h exp=%h", t, got, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      value = 16'($urandom);
      load  = ($urandom_range(0, 3) == 0);
      lzb   = 1'($urandom);
      blank = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      tick();
      got = {frame, digit_en, bcd_out}; exp_v = model_out();
      n_cmp++;
      if (got !== exp_v || $countones(digit_en) > 1) begin
        n_fail++; $display("FAIL random t=%0d got=%h exp=%h", t, got, exp_v);
      end
    end
    load = 1'b0; blank = 1'b0; lzb = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    model_reset();
    test_reset();
    test_basic_scan();
    test_lzb();
    test_load_midslot();
    test_blank();
    test_async_reset();
    test_nonbcd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
